// File: rtl/subsys_reset_sequencer.sv
// Reset sequencer for the PCIe/DDR3 subsystem: qualifies the MMCM locks, releases the resets in order
// and recovers on loss of lock or ready. Define SUBSYS_HEARTBEAT_EN to drive leds[7] from a heartbeat.
module subsys_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGGER_CYCLES     = 16,
    parameter int unsigned DDR_TIMEOUT_CYCLES = 16777216,
    parameter int unsigned CNT_W              = 25
) (
    input  logic       pcie_clk_125MHz,
    input  logic       sys_rst_n,
    input  logic       pcie_mmcm_locked,
    input  logic       ddr_mmcm_locked,
    input  logic       ddr_rdy,
    input  logic       sw_reset_req,
    output logic       mmcms_locked,
    output logic       ic_rst_n,
    output logic       ddr_user_rst,
    output logic       dma_rst_n,
    output logic       run,
    output logic       fault,
    output logic [2:0] state_code,
    output logic [7:0] lost_lock_cnt,
    output logic [7:0] leds
);

    localparam logic [CNT_W-1:0] LockLoad    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] StaggerLoad = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLoad = CNT_W'(DDR_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRelDdr   = 3'd3,
        StWaitDdr  = 3'd4,
        StRelDma   = 3'd5,
        StRun      = 3'd6,
        StFault    = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pcie_sync_q, ddr_sync_q, rdy_sync_q, rst_sync_q;
    logic             lk, rdy_sync;
    logic             mmcms_locked_q;
    logic             ic_rst_n_q, ic_rst_n_d;
    logic             ddr_user_rst_q, ddr_user_rst_d;
    logic             dma_rst_n_q, dma_rst_n_d;
    logic             run_q, run_d;
    logic             fault_q, fault_d;
    logic [7:0]       lost_q, lost_d;
    logic             heartbeat;

    always_ff @(posedge pcie_clk_125MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pcie_sync_q <= '0;
            ddr_sync_q  <= '0;
            rdy_sync_q  <= '0;
            rst_sync_q  <= '0;
        end else begin
            pcie_sync_q <= {pcie_sync_q[0], pcie_mmcm_locked};
            ddr_sync_q  <= {ddr_sync_q[0], ddr_mmcm_locked};
            rdy_sync_q  <= {rdy_sync_q[0], ddr_rdy};
            rst_sync_q  <= {rst_sync_q[0], 1'b1};
        end
    end

    assign lk       = pcie_sync_q[1] & ddr_sync_q[1];
    assign rdy_sync = rdy_sync_q[1];

    always_ff @(posedge pcie_clk_125MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            mmcms_locked_q <= 1'b0;
            ic_rst_n_q     <= 1'b0;
            ddr_user_rst_q <= 1'b1;
            dma_rst_n_q    <= 1'b0;
            run_q          <= 1'b0;
            fault_q        <= 1'b0;
            lost_q         <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mmcms_locked_q <= lk;
            ic_rst_n_q     <= ic_rst_n_d;
            ddr_user_rst_q <= ddr_user_rst_d;
            dma_rst_n_q    <= dma_rst_n_d;
            run_q          <= run_d;
            fault_q        <= fault_d;
            lost_q         <= lost_d;
        end
    end

    // Loss of lock is checked before counter expiry so it always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sw_reset_req) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: state_d = StWaitLock;
                StWaitLock: begin
                    cnt_d = LockLoad;
                    if (lk) state_d = StStable;
                end
                StStable, StRelDdr, StRelDma: begin
                    if (!lk) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == '0) begin
                        if (state_q == StStable) begin
                            state_d = StRelDdr;
                            cnt_d   = StaggerLoad;
                        end else if (state_q == StRelDdr) begin
                            state_d = StWaitDdr;
                            cnt_d   = TimeoutLoad;
                        end else begin
                            state_d = StRun;
                        end
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StWaitDdr: begin
                    if (!lk) begin
                        state_d = StWaitLock;
                    end else if (rdy_sync) begin
                        state_d = StRelDma;
                        cnt_d   = StaggerLoad;
                    end else if (cnt_q == '0) begin
                        state_d = StFault;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StRun: if (!lk || !rdy_sync) state_d = StWaitLock;
                StFault: state_d = StFault;
                default: state_d = StIdle;
            endcase
        end
    end

    // Reset outputs are a pure decode of the next state, so reassertion is simultaneous.
    always_comb begin
        ic_rst_n_d     = 1'b0;
        ddr_user_rst_d = 1'b1;
        dma_rst_n_d    = 1'b0;
        run_d          = 1'b0;
        fault_d        = 1'b0;
        lost_d         = lost_q;
        case (state_d)
            StRelDdr: ic_rst_n_d = 1'b1;
            StWaitDdr, StRelDma: begin
                ic_rst_n_d     = 1'b1;
                ddr_user_rst_d = 1'b0;
            end
            StRun: begin
                ic_rst_n_d     = 1'b1;
                ddr_user_rst_d = 1'b0;
                dma_rst_n_d    = 1'b1;
                run_d          = 1'b1;
            end
            StFault: fault_d = 1'b1;
            default: ;
        endcase
        if (state_q == StRun && state_d == StWaitLock && lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
        end
    end

`ifdef SUBSYS_HEARTBEAT_EN
    logic [26:0] hb_q;

    always_ff @(posedge pcie_clk_125MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) hb_q <= '0;
        else            hb_q <= hb_q + 27'd1;
    end

    assign heartbeat = hb_q[26];
`else
    assign heartbeat = run_q;
`endif

    assign mmcms_locked  = mmcms_locked_q;
    assign ic_rst_n      = ic_rst_n_q;
    assign ddr_user_rst  = ddr_user_rst_q;
    assign dma_rst_n     = dma_rst_n_q;
    assign run           = run_q;
    assign fault         = fault_q;
    assign state_code    = state_q;
    assign lost_lock_cnt = lost_q;
    assign leds = {heartbeat, fault_q, run_q, dma_rst_n_q, ~ddr_user_rst_q, ic_rst_n_q,
                   mmcms_locked_q, rst_sync_q[1]};

endmodule

// File: doc/subsys_reset_sequencer.md
Name: subsys_reset_sequencer

Overview:
Sequences bring-up and recovery of the Kintex PCIe/DDR3 subsystem. It qualifies the PCIe MMCM lock and the DDR ready indication, then releases the downstream resets in a fixed order: interconnect, then DDR user logic, then DMA. It detects loss of lock or ready, and DDR calibration timeout, and reports status on the board LEDs. It sits in the wrapper next to the block design and runs in the PCIe 125 MHz domain.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive cycles both lock inputs must stay high before sequencing starts (min 2).
STAGGER_CYCLES, 16, delay between successive reset releases (min 1).
DDR_TIMEOUT_CYCLES, 16777216, maximum cycles to wait for ddr_rdy after the DDR reset is released.
CNT_W, 25, width of the shared down-counter; must hold the largest cycle parameter.

Ports:
pcie_clk_125MHz  in  1  sole clock.
sys_rst_n  in  1  asynchronous, active-low reset.
pcie_mmcm_locked  in  1  PCIe MMCM lock, asynchronous; 2-flop synchronised internally.
ddr_mmcm_locked  in  1  DDR MMCM lock, asynchronous; 2-flop synchronised.
ddr_rdy  in  1  DDR calibration complete, asynchronous; 2-flop synchronised.
sw_reset_req  in  1  single-cycle request to re-run the full sequence.
mmcms_locked  out  1  registered AND of the synchronised locks; feeds reset_logic_mmcm_locked_in.
ic_rst_n  out  1  interconnect reset, active-low.
ddr_user_rst  out  1  DDR user-logic reset, active-high.
dma_rst_n  out  1  DMA engine reset, active-low.
run  out  1  high only in RUN.
fault  out  1  high only in FAULT.
state_code  out  3  encoded current state.
lost_lock_cnt  out  8  saturating count of RUN-to-recovery events.
leds  out  8  {heartbeat, fault, run, dma_rst_n, ~ddr_user_rst, ic_rst_n, mmcms_locked, sys_rst_n synchronised}.

Behaviour:
- All outputs are registered. Reset values: mmcms_locked=0, ic_rst_n=0, ddr_user_rst=1, dma_rst_n=0, run=0, fault=0, state_code=0, lost_lock_cnt=0, heartbeat=0.
- lk = pcie_lock_sync & ddr_lock_sync. mmcms_locked follows lk one cycle late.
- States and state_code:
  - IDLE (0): all resets asserted. Next cycle → WAIT_LOCK.
  - WAIT_LOCK (1): load cnt=LOCK_STABLE_CYCLES-1. On lk → STABLE.
  - STABLE (2): decrement cnt while lk. If lk drops → WAIT_LOCK (counter reloads). At cnt==0: ic_rst_n←1, cnt←STAGGER_CYCLES-1 → REL_DDR.
  - REL_DDR (3): at cnt==0: ddr_user_rst←0, cnt←DDR_TIMEOUT_CYCLES-1 → WAIT_DDR.
  - WAIT_DDR (4): if rdy_sync → cnt←STAGGER_CYCLES-1 → REL_DMA. If cnt==0 without rdy_sync → FAULT.
  - REL_DMA (5): at cnt==0: dma_rst_n←1 → RUN.
  - RUN (6): run=1. If lk==0 or rdy_sync==0: reassert all resets, increment lost_lock_cnt (saturates at 255) → WAIT_LOCK.
  - FAULT (7): fault=1, all resets asserted. Stays here until sw_reset_req or sys_rst_n.
- Priority in states 2–6: loss of lk wins over counter expiry in the same cycle; go to WAIT_LOCK and reassert all resets. lost_lock_cnt increments only when leaving RUN.
- sw_reset_req in any state: all resets asserted next cycle → IDLE. It has priority over every other transition. lost_lock_cnt is not changed.
- Reset release order is strict: ic_rst_n, then ddr_user_rst, then dma_rst_n, each STAGGER_CYCLES apart. Reassertion of all three is simultaneous.
- In ddr_rdy-lost recovery, ddr_user_rst reasserts on the same edge as dma_rst_n.

Optional Feature:
SUBSYS_HEARTBEAT_EN:
- Defined: a free-running 27-bit counter drives leds[7] from bit 26 (toggles about every 0.54 s).
- Undefined: leds[7] is tied to run and the counter is not instantiated.

Test Plan:
- Params LOCK_STABLE=8, STAGGER=4, TIMEOUT=64. Both locks high, ddr_rdy high 20 cycles after REL_DDR. Required: ic_rst_n rises at the 8th cycle after sync'd lk; ddr_user_rst falls 4 cycles later; dma_rst_n rises 4 cycles after rdy_sync; run=1, state_code=6.
- Glitch pcie_mmcm_locked low for 1 cycle at cnt=3 in STABLE. Required: return to WAIT_LOCK; ic_rst_n stays 0; full 8-cycle qualification restarts.
- ddr_rdy never asserts. Required: fault=1 and state_code=7 exactly 64 cycles after ddr_user_rst falls; resets asserted; sw_reset_req pulse → IDLE, then normal sequence.
- In RUN, drop ddr_mmcm_locked. Required: all resets asserted within 3 cycles (2 sync + 1), lost_lock_cnt=1. Repeat 300 times → lost_lock_cnt=255.
- sw_reset_req on the same cycle as rdy_sync in WAIT_DDR. Required: IDLE next cycle, dma_rst_n stays 0.
- sys_rst_n asserted mid-REL_DMA. Required: all outputs return to reset values immediately, without waiting for a clock edge.
